// File: rtl/forwarding_unit.sv
// ---------------------------------------------------------------------------
// forwarding_unit
//
// Operand-bypass selector for one register read port in the execute stage.
// The source register index is compared against the destination indices of
// the instructions in MEM and WB. The newest usable value is returned: the
// MEM result first, then the WB result, then the register-file read data.
// The selection is purely combinational. A registered copy of the select
// code is kept for debug and hazard logic.
//
// Optional build macro: FWD_STATS_EN
//   When defined, two saturating 16-bit counters are added. They count the
//   edges on which MEM or WB forwarding was selected.
//
// Parameters
//   REG_INDEX_BIT_WIDTH  width of register indices
//   bitwidth             width of data words
//   NOFWD_OPCODE         opcode whose result cannot be forwarded from its stage
//
// Ports
//   clk             in   system clock, all state is rising-edge
//   reset           in   synchronous active-high reset
//   reg_index       in   source register index of the operand
//   reg_data        in   register-file read value for reg_index
//   MEM_opcode      in   opcode of the instruction in MEM
//   MEM_index       in   destination index in MEM
//   MEM_data        in   result value in MEM
//   WB_opcode       in   opcode of the instruction in WB
//   WB_index        in   destination index in WB
//   WB_data         in   result value in WB
//   data_forwarded  out  selected operand (combinational)
//   fwd_src         out  select code: 00 reg, 01 MEM, 10 WB (combinational)
//   fwd_src_q       out  fwd_src registered on clk
//   mem_fwd_count   out  (FWD_STATS_EN only) count of MEM-forward edges
//   wb_fwd_count    out  (FWD_STATS_EN only) count of WB-forward edges
// ---------------------------------------------------------------------------
module forwarding_unit #(
  parameter int          REG_INDEX_BIT_WIDTH = 4,
  parameter int          bitwidth            = 32,
  parameter logic [3:0]  NOFWD_OPCODE        = 4'b1100
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] reg_index,
  input  logic [bitwidth-1:0]            reg_data,
  input  logic [3:0]                     MEM_opcode,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] MEM_index,
  input  logic [bitwidth-1:0]            MEM_data,
  input  logic [3:0]                     WB_opcode,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] WB_index,
  input  logic [bitwidth-1:0]            WB_data,
  output logic [bitwidth-1:0]            data_forwarded,
  output logic [1:0]                     fwd_src,
  output logic [1:0]                     fwd_src_q
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]                    mem_fwd_count,
  output logic [15:0]                    wb_fwd_count
`endif
);

  localparam logic [1:0] SRC_REG = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_WB  = 2'b10;

  logic memMatch;
  logic memHit;
  logic wbHit;
  logic wbBlocked;

  // A MEM instruction that writes our register but cannot forward still
  // makes the WB copy stale. In that case WB forwarding is blocked, and the
  // register-file value is used instead.
  assign memMatch  = (reg_index == MEM_index);
  assign memHit    = memMatch && (MEM_opcode != NOFWD_OPCODE);
  assign wbBlocked = memMatch && (MEM_opcode == NOFWD_OPCODE);
  assign wbHit     = (reg_index == WB_index) && (WB_opcode != NOFWD_OPCODE);

  // Priority select between MEM, WB and the register file. The outputs take
  // their register-file defaults first, so every path is fully specified.
  always_comb begin
    fwd_src        = SRC_REG;
    data_forwarded = reg_data;
    if (memHit) begin
      fwd_src        = SRC_MEM;
      data_forwarded = MEM_data;
    end else if (wbHit && !wbBlocked) begin
      fwd_src        = SRC_WB;
      data_forwarded = WB_data;
    end
  end

  // Registered copy of the select code. It lags fwd_src by one cycle, and
  // reset forces it back to the register-file code.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_src_q <= SRC_REG;
    end else begin
      fwd_src_q <= fwd_src;
    end
  end

`ifdef FWD_STATS_EN
  logic [15:0] memCount_q;
  logic [15:0] memCount_d;
  logic [15:0] wbCount_q;
  logic [15:0] wbCount_d;

  // Next-state for the statistics counters. Each counter steps once per edge
  // on which its source is selected. Each one holds at all-ones rather than
  // wrapping.
  always_comb begin
    memCount_d = memCount_q;
    wbCount_d  = wbCount_q;
    if ((fwd_src == SRC_MEM) && (memCount_q != 16'hFFFF)) begin
      memCount_d = memCount_q + 16'd1;
    end
    if ((fwd_src == SRC_WB) && (wbCount_q != 16'hFFFF)) begin
      wbCount_d = wbCount_q + 16'd1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      memCount_q <= 16'd0;
      wbCount_q  <= 16'd0;
    end else begin
      memCount_q <= memCount_d;
      wbCount_q  <= wbCount_d;
    end
  end

  assign mem_fwd_count = memCount_q;
  assign wb_fwd_count  = wbCount_q;
`endif

endmodule

// File: tb/tb_forwarding_unit.sv
// ---------------------------------------------------------------------------
// tb_forwarding_unit
//
// Scoreboard bench for forwarding_unit. The stimulus process drives one
// operand lookup per cycle. For each lookup it pushes the expected response
// into a queue. The expected response is computed by a reference model built
// from the forwarding rules. A separate monitor pops each entry on the
// falling edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_forwarding_unit;

  localparam logic [3:0] NOFWD = 4'b1100;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  reg_index;
  logic [31:0] reg_data;
  logic [3:0]  MEM_opcode;
  logic [3:0]  MEM_index;
  logic [31:0] MEM_data;
  logic [3:0]  WB_opcode;
  logic [3:0]  WB_index;
  logic [31:0] WB_data;
  logic [31:0] data_forwarded;
  logic [1:0]  fwd_src;
  logic [1:0]  fwd_src_q;
`ifdef FWD_STATS_EN
  logic [15:0] mem_fwd_count;
  logic [15:0] wb_fwd_count;
`endif

  typedef struct {
    logic [31:0] data;
    logic [1:0]  src;
    logic [1:0]  srcQ;
    bit          checkQ;
    int          memCnt;
    int          wbCnt;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  // Reference-model history: what was applied before the most recent edge.
  bit         havePrev = 1'b0;
  bit         prevRst;
  logic [1:0] prevSrc;
  logic [1:0] mdlQ;
  int         mdlMem = 0;
  int         mdlWb  = 0;

  forwarding_unit dut (
    .clk            (clk),
    .reset          (reset),
    .reg_index      (reg_index),
    .reg_data       (reg_data),
    .MEM_opcode     (MEM_opcode),
    .MEM_index      (MEM_index),
    .MEM_data       (MEM_data),
    .WB_opcode      (WB_opcode),
    .WB_index       (WB_index),
    .WB_data        (WB_data),
    .data_forwarded (data_forwarded),
    .fwd_src        (fwd_src),
    .fwd_src_q      (fwd_src_q)
`ifdef FWD_STATS_EN
    ,
    .mem_fwd_count  (mem_fwd_count),
    .wb_fwd_count   (wb_fwd_count)
`endif
  );

  always #5 clk = ~clk;

  // The forwarding rules written directly as a decision list. A MEM writer of
  // the same register always wins: it either forwards, or it is
  // non-forwardable and hides WB.
  function automatic void refSelect(
    input  logic [3:0]  idx,   input logic [31:0] rdata,
    input  logic [3:0]  mop,   input logic [3:0]  midx, input logic [31:0] mdata,
    input  logic [3:0]  wop,   input logic [3:0]  widx, input logic [31:0] wdata,
    output logic [31:0] d,     output logic [1:0] s);
    if (idx == midx) begin
      if (mop != NOFWD) begin d = mdata; s = 2'd1; end
      else              begin d = rdata; s = 2'd0; end
    end else if (idx == widx && wop != NOFWD) begin
      d = wdata; s = 2'd2;
    end else begin
      d = rdata; s = 2'd0;
    end
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Drive one lookup just after a rising edge. The model state is first
  // advanced past that edge, then the expected response is queued.
  task automatic applyStimulus(
    input logic [3:0] idx, input logic [31:0] rdata,
    input logic [3:0] mop, input logic [3:0]  midx, input logic [31:0] mdata,
    input logic [3:0] wop, input logic [3:0]  widx, input logic [31:0] wdata,
    input logic       rst);
    exp_t e;
    @(posedge clk);
    #1;
    if (havePrev) begin
      if (prevRst) begin
        mdlQ = 2'd0; mdlMem = 0; mdlWb = 0;
      end else begin
        mdlQ = prevSrc;
        if (prevSrc == 2'd1) mdlMem++;
        if (prevSrc == 2'd2) mdlWb++;
      end
    end
    reset = rst; reg_index = idx; reg_data = rdata;
    MEM_opcode = mop; MEM_index = midx; MEM_data = mdata;
    WB_opcode = wop; WB_index = widx; WB_data = wdata;
    refSelect(idx, rdata, mop, midx, mdata, wop, widx, wdata, e.data, e.src);
    e.srcQ   = mdlQ;
    e.checkQ = havePrev;
    e.memCnt = sat16(mdlMem);
    e.wbCnt  = sat16(mdlWb);
    sbq.push_back(e);
    prevRst  = rst;
    prevSrc  = e.src;
    havePrev = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: on each falling edge, pop one queued expectation and compare it
  // with what the DUT is presenting.
  exp_t mon;
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon = sbq.pop_front();
      checkOutput("data_forwarded", data_forwarded, mon.data);
      checkOutput("fwd_src", {30'd0, fwd_src}, {30'd0, mon.src});
      if (mon.checkQ) checkOutput("fwd_src_q", {30'd0, fwd_src_q}, {30'd0, mon.srcQ});
`ifdef FWD_STATS_EN
      if (mon.checkQ) begin
        checkOutput("mem_fwd_count", {16'd0, mem_fwd_count}, mon.memCnt[31:0]);
        checkOutput("wb_fwd_count", {16'd0, wb_fwd_count}, mon.wbCnt[31:0]);
      end
`endif
    end
  end

  function automatic logic [3:0] pickOpcode();
    case ($urandom_range(0, 3))
      0:       return NOFWD;
      1:       return 4'b0010;
      2:       return 4'b0011;
      default: return 4'($urandom);
    endcase
  endfunction

  initial begin
    int drain;
    reset = 1'b1; reg_index = '0; reg_data = '0;
    MEM_opcode = 4'b0010; MEM_index = '0; MEM_data = '0;
    WB_opcode = 4'b0010; WB_index = '0; WB_data = '0;

    // Directed sequence from the plan, beginning with a reset cycle.
    applyStimulus(4'd0, 32'd0, 4'b0010, 4'd1, 32'd1, 4'b0010, 4'd2, 32'd2, 1'b1);
    applyStimulus(4'd0, 32'd0, 4'b0010, 4'd1, 32'd1, 4'b0010, 4'd2, 32'd2, 1'b0);
    applyStimulus(4'd0, 32'd0, 4'b0010, 4'd0, 32'd1, 4'b0010, 4'd2, 32'd2, 1'b0);
    applyStimulus(4'd0, 32'd0, 4'b0010, 4'd0, 32'd1, 4'b0010, 4'd2, 32'd2, 1'b0);
    applyStimulus(4'd0, 32'd0, 4'b0010, 4'd1, 32'd1, 4'b0010, 4'd0, 32'd2, 1'b0);
    applyStimulus(4'd0, 32'd0, 4'b0010, 4'd0, 32'd1, 4'b0010, 4'd0, 32'd2, 1'b0);
    applyStimulus(4'd0, 32'd0, 4'b1100, 4'd0, 32'd1, 4'b0010, 4'd0, 32'd2, 1'b0);
    applyStimulus(4'd0, 32'd0, 4'b0011, 4'd0, 32'd1, 4'b0010, 4'd0, 32'd2, 1'b0);
    // Reset during a MEM hit, followed by three MEM-hit edges.
    applyStimulus(4'd0, 32'd0, 4'b0010, 4'd0, 32'd1, 4'b0010, 4'd2, 32'd2, 1'b1);
    for (int i = 0; i < 4; i++)
      applyStimulus(4'd0, 32'd0, 4'b0010, 4'd0, 32'd1, 4'b0010, 4'd2, 32'd2, 1'b0);

    // Randomized lookups on a small index range so that hits are frequent.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(4'($urandom_range(0, 3)), $urandom, pickOpcode(),
                    4'($urandom_range(0, 3)), $urandom, pickOpcode(),
                    4'($urandom_range(0, 3)), $urandom,
                    ($urandom_range(0, 19) == 0));
    end

    drain = 0;
    while (sbq.size() > 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    if (sbq.size() > 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/forwarding_unit.md
Name: forwarding_unit

Overview:
- Operand-bypass selector for one register read port of the pipeline, sitting in the execute stage.
- Compares the source register index against the destination indices held in the MEM and WB stages.
- Returns the newest available value: MEM result, else WB result, else the register-file read data.
- Selection is combinational; a registered copy of the select decision is kept for debug and hazard logic.

Parameters:
- REG_INDEX_BIT_WIDTH, 4, width of register indices.
- bitwidth, 32, width of data words.
- NOFWD_OPCODE, 4'b1100, opcode value whose result is not forwardable from that stage.

Ports:
- clk  input  1  system clock; all state is rising-edge.
- reset  input  1  synchronous, active-high reset.
- reg_index  input  REG_INDEX_BIT_WIDTH  source register index of the operand.
- reg_data  input  bitwidth  register-file read value for reg_index.
- MEM_opcode  input  4  opcode of the instruction in MEM.
- MEM_index  input  REG_INDEX_BIT_WIDTH  destination index in MEM.
- MEM_data  input  bitwidth  result value in MEM.
- WB_opcode  input  4  opcode of the instruction in WB.
- WB_index  input  REG_INDEX_BIT_WIDTH  destination index in WB.
- WB_data  input  bitwidth  result value in WB.
- data_forwarded  output  bitwidth  selected operand (combinational).
- fwd_src  output  2  combinational select code: 00 = reg, 01 = MEM, 10 = WB, 11 never driven.
- fwd_src_q  output  2  fwd_src registered on clk.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- mem_hit: (reg_index == MEM_index) and (MEM_opcode != NOFWD_OPCODE).
- wb_hit: (reg_index == WB_index) and (WB_opcode != NOFWD_OPCODE).
- Blocking rule: when MEM_opcode == NOFWD_OPCODE and reg_index == MEM_index, the WB value is stale relative to the pending MEM write. WB forwarding is suppressed and reg_data is selected.
- Priority:
  - mem_hit selects MEM_data, fwd_src = 01.
  - Else wb_hit (not blocked) selects WB_data, fwd_src = 10.
  - Else reg_data, fwd_src = 00.
- Index 0 is an ordinary register; no hard-wired-zero exclusion.
- All other opcodes (e.g. 0010, 0011) are forwardable.
- data_forwarded and fwd_src are purely combinational with zero latency. They are unaffected by clk and reset.
- fwd_src_q:
  - Resets to 00.
  - Otherwise loads fwd_src each rising edge, giving one cycle of latency.
  - If reset is asserted mid-operation, fwd_src_q goes to 00 on the next edge regardless of inputs.
- No X propagation: every select path is fully specified.

Optional Feature:
- Macro FWD_STATS_EN.
- When defined, adds two outputs, mem_fwd_count and wb_fwd_count, each 16 bits.
  - Each increments on a rising edge when fwd_src is 01 or 10 respectively.
  - Both saturate at 16'hFFFF.
  - Both clear to 0 on reset.
- When not defined, these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- reg_index=0, MEM_index=1, WB_index=2, reg_data=0, MEM_data=1, WB_data=2, both opcodes 0010 -> data_forwarded=0, fwd_src=00.
- Same, with MEM_index=0 -> data_forwarded=1, fwd_src=01; fwd_src_q=01 one clock later.
- MEM_index=1, WB_index=0 -> data_forwarded=2, fwd_src=10.
- MEM_index=WB_index=0 -> data_forwarded=1 (MEM priority).
- Then MEM_opcode=1100 -> data_forwarded=0 (WB blocked). Then MEM_opcode=0011 -> data_forwarded=1.
- Assert reset for one edge while fwd_src=01:
  - fwd_src_q=00 after the edge.
  - With FWD_STATS_EN, both counters read 0, then mem_fwd_count=3 after three further edges with MEM hits.
